// File: rtl/pic_rom_scheduler.sv
// pic_rom_scheduler: resolves the active picture region per pixel, issues one
// read to the shared synchronous picture ROM and returns a registered RRRGGGBB
// colour with its region flags, three clocks after the pixel strobe. Also runs
// the RING blink sequencer used while the alarm is ringing.
module pic_rom_scheduler #(
    parameter int BLINK_FRAMES = 30,
    parameter int H_LAST       = 799,
    parameter int V_LAST       = 524
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        video_on,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        ring_active,
    output logic        rom_en,
    output logic [14:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic [7:0]  pic_RGB,
    output logic        pic_on,
    output logic        pic_ring_on,
    output logic        pic_ringball_on
);
    // Region table, index order is also the priority order (0 wins).
    // 0 HORA, 1 FECHA, 2 TIMER, 3 RING, 4 RINGBALL, 5 LOGO.
    localparam int NREG = 6;
    localparam logic [2:0] TAG_NONE = 3'd7;
    localparam logic [2:0] TAG_RING = 3'd3;
    localparam logic [2:0] TAG_BALL = 3'd4;
    localparam logic [9:0]  REG_XL   [NREG] = '{10'd256, 10'd128, 10'd416, 10'd512, 10'd544, 10'd0};
    localparam logic [9:0]  REG_YT   [NREG] = '{10'd0,   10'd416, 10'd416, 10'd128, 10'd64,  10'd0};
    localparam logic [9:0]  REG_W    [NREG] = '{10'd128, 10'd80,  10'd80,  10'd128, 10'd48,  10'd128};
    localparam logic [9:0]  REG_H    [NREG] = '{10'd64,  10'd32,  10'd32,  10'd64,  10'd48,  10'd16};
    localparam logic [14:0] REG_BASE [NREG] = '{15'd0, 15'd8192, 15'd10752, 15'd13312, 15'd21504, 15'd23808};
    localparam int CNT_W = $clog2(BLINK_FRAMES) + 1;

    typedef enum logic [1:0] {
        BLINK_OFF    = 2'd0,
        BLINK_ON_PH  = 2'd1,
        BLINK_OFF_PH = 2'd2
    } blink_state_t;

    blink_state_t     blink_state_q, blink_state_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             ring_en;
    logic             end_of_frame;

    logic [NREG-1:0]  reg_hit;
    logic [14:0]      reg_addr [NREG];
    logic [2:0]       sel_tag;
    logic [14:0]      sel_addr;

    // Pipeline registers: stage 0 (address issue), stage 1 (ROM access), stage 2 (output).
    logic        rom_en_q;
    logic [14:0] rom_addr_q;
    logic [2:0]  tag0_q, tag1_q;
    logic        vid0_q;
    logic        v0_q, v1_q;
    logic [7:0]  pic_rgb_q;
    logic        pic_on_q, pic_ring_on_q, pic_ringball_on_q;

    assign ring_en      = ring_active && (blink_state_q == BLINK_ON_PH);
    assign end_of_frame = p_tick && (pixel_x == 10'(H_LAST)) && (pixel_y == 10'(V_LAST));

    // Per-region hit test and row-major address; widths of 80 and 48 use shift-adds.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_region
            localparam logic [9:0] W_GI = REG_W[gi];
            logic [9:0]  dx, dy;
            logic [14:0] dy_ext, row_off;
            logic        in_box, en;

            assign dx     = pixel_x - REG_XL[gi];
            assign dy     = pixel_y - REG_YT[gi];
            assign dy_ext = {5'd0, dy};
            assign in_box = (pixel_x >= REG_XL[gi]) && (pixel_x < REG_XL[gi] + REG_W[gi]) &&
                            (pixel_y >= REG_YT[gi]) && (pixel_y < REG_YT[gi] + REG_H[gi]);

            if (W_GI == 10'd128) begin : g_w128
                assign row_off = dy_ext << 7;
            end else if (W_GI == 10'd80) begin : g_w80
                assign row_off = (dy_ext << 6) + (dy_ext << 4);
            end else begin : g_w48
                assign row_off = (dy_ext << 5) + (dy_ext << 4);
            end

            if (gi == 3) begin : g_en_ring
                assign en = ring_en;
            end else if (gi == 4) begin : g_en_ball
                assign en = ring_active;
            end else begin : g_en_plain
                assign en = 1'b1;
            end

            assign reg_hit[gi]  = in_box && en && video_on;
            assign reg_addr[gi] = REG_BASE[gi] + row_off + {5'd0, dx};
        end
    endgenerate

    // Priority select: scan from lowest to highest priority so the highest hit wins.
    always_comb begin
        sel_tag  = TAG_NONE;
        sel_addr = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (reg_hit[i]) begin
                sel_tag  = 3'(i);
                sel_addr = reg_addr[i];
            end
        end
    end

    // Blink sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_state_q <= BLINK_OFF;
            frame_cnt_q   <= '0;
        end else begin
            blink_state_q <= blink_state_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    // Blink next state: dropping the alarm always wins over an end of frame.
    always_comb begin
        blink_state_d = blink_state_q;
        frame_cnt_d   = frame_cnt_q;
        if (!ring_active) begin
            blink_state_d = BLINK_OFF;
            frame_cnt_d   = '0;
        end else begin
            case (blink_state_q)
                BLINK_OFF: begin
                    blink_state_d = BLINK_ON_PH;
                    frame_cnt_d   = '0;
                end
                BLINK_ON_PH, BLINK_OFF_PH: begin
                    if (end_of_frame) begin
                        if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                            frame_cnt_d   = '0;
                            blink_state_d = (blink_state_q == BLINK_ON_PH) ? BLINK_OFF_PH : BLINK_ON_PH;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    blink_state_d = BLINK_OFF;
                    frame_cnt_d   = '0;
                end
            endcase
        end
    end

    // Three-stage pixel pipeline; reset drops every pixel in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_en_q          <= 1'b0;
            rom_addr_q        <= '0;
            tag0_q            <= TAG_NONE;
            tag1_q            <= TAG_NONE;
            vid0_q            <= 1'b0;
            v0_q              <= 1'b0;
            v1_q              <= 1'b0;
            pic_rgb_q         <= 8'h00;
            pic_on_q          <= 1'b0;
            pic_ring_on_q     <= 1'b0;
            pic_ringball_on_q <= 1'b0;
        end else begin
            rom_en_q <= p_tick && (sel_tag != TAG_NONE);
            v0_q     <= p_tick;
            v1_q     <= v0_q;
            if (p_tick) begin
                rom_addr_q <= sel_addr;
                tag0_q     <= sel_tag;
                vid0_q     <= video_on;
            end
            if (v0_q) begin
                tag1_q <= vid0_q ? tag0_q : TAG_NONE;
            end
            if (v1_q) begin
                pic_rgb_q         <= (tag1_q != TAG_NONE) ? rom_data : 8'h00;
                pic_on_q          <= tag1_q inside {3'd0, 3'd1, 3'd2, 3'd5};
                pic_ring_on_q     <= (tag1_q == TAG_RING);
                pic_ringball_on_q <= (tag1_q == TAG_BALL);
            end
        end
    end

    assign rom_en          = rom_en_q;
    assign rom_addr        = rom_addr_q;
    assign pic_RGB         = pic_rgb_q;
    assign pic_on          = pic_on_q;
    assign pic_ring_on     = pic_ring_on_q;
    assign pic_ringball_on = pic_ringball_on_q;

endmodule

// File: tb/tb_pic_rom_scheduler.sv
// Testbench for pic_rom_scheduler: directed pixels with hand-computed
// addresses plus a region/queue model compared against the DUT every cycle.
module tb_pic_rom_scheduler;
    localparam int BF = 2;
    localparam int HL = 799;
    localparam int VL = 524;

    localparam int RXL  [6] = '{256, 128, 416, 512, 544, 0};
    localparam int RYT  [6] = '{0, 416, 416, 128, 64, 0};
    localparam int RW   [6] = '{128, 80, 80, 128, 48, 128};
    localparam int RH   [6] = '{64, 32, 32, 64, 48, 16};
    localparam int RB   [6] = '{0, 8192, 10752, 13312, 21504, 23808};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p_tick = 1'b0;
    logic        video_on = 1'b0;
    logic [9:0]  pixel_x = '0;
    logic [9:0]  pixel_y = '0;
    logic        ring_active = 1'b0;
    logic        rom_en;
    logic [14:0] rom_addr;
    logic [7:0]  rom_data = 8'h00;
    logic [7:0]  pic_RGB;
    logic        pic_on, pic_ring_on, pic_ringball_on;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    pic_rom_scheduler #(.BLINK_FRAMES(BF), .H_LAST(HL), .V_LAST(VL)) dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .ring_active(ring_active),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .pic_RGB(pic_RGB), .pic_on(pic_on), .pic_ring_on(pic_ring_on),
        .pic_ringball_on(pic_ringball_on)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_val(input int a);
        logic [14:0] av;
        av = 15'(a);
        if (a == 1344) return 8'hA5;
        return (av[7:0] ^ {av[14:8], 1'b0}) + 8'h11;
    endfunction

    // Synchronous ROM stand-in: data one clock after the enabled address.
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_val(int'(rom_addr));
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: first enabled region in priority order, plain multiply addressing.
    function automatic void ref_pix(input int x, input int y, input bit vid,
                                    input bit ring_en, input bit ball_en,
                                    output int tag, output int addr);
        bit found;
        tag = 7;
        addr = 0;
        found = 1'b0;
        if (vid) begin
            for (int r = 0; r < 6; r++) begin
                if (!found && !(r == 3 && !ring_en) && !(r == 4 && !ball_en) &&
                    x >= RXL[r] && x < RXL[r] + RW[r] && y >= RYT[r] && y < RYT[r] + RH[r]) begin
                    found = 1'b1;
                    tag = r;
                    addr = RB[r] + (y - RYT[r]) * RW[r] + (x - RXL[r]);
                end
            end
        end
    endfunction

    typedef struct {
        int due;
        int tag;
        int addr;
    } ev_t;

    ev_t q[$];
    int  cyc = 0;
    bit  m_en = 1'b0;
    int  m_addr = 0;
    int  m_tag = 7;
    int  m_rgb = 0;
    bit  ring_prev = 1'b0;
    int  frames = 0;

    // Model: sample inputs at each edge, schedule outputs two edges later.
    initial begin
        ev_t ev;
        int tag, addr;
        bit phase_on, eof;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                q.delete();
                m_en = 1'b0;
                m_tag = 7;
                m_rgb = 0;
                ring_prev = 1'b0;
                frames = 0;
            end else begin
                while (q.size() > 0 && q[0].due == cyc) begin
                    ev = q.pop_front();
                    m_tag = ev.tag;
                    m_rgb = (ev.tag != 7) ? int'(rom_val(ev.addr)) : 0;
                end
                phase_on = ring_prev && (((frames / BF) % 2) == 0);
                ref_pix(int'(pixel_x), int'(pixel_y), video_on, ring_active && phase_on,
                        ring_active, tag, addr);
                m_en = p_tick && (tag != 7);
                if (m_en) m_addr = addr;
                if (p_tick) q.push_back('{cyc + 2, tag, addr});
                eof = p_tick && int'(pixel_x) == HL && int'(pixel_y) == VL;
                if (!ring_active) begin
                    ring_prev = 1'b0;
                    frames = 0;
                end else if (!ring_prev) begin
                    ring_prev = 1'b1;
                    frames = 0;
                end else if (eof) begin
                    frames++;
                end
            end
        end
    end

    // Every-cycle compare against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("cyc_rom_en", int'(rom_en), int'(m_en));
                if (m_en) chk("cyc_rom_addr", int'(rom_addr), m_addr);
                chk("cyc_pic_RGB", int'(pic_RGB), m_rgb);
                chk("cyc_pic_on", int'(pic_on), int'(m_tag == 0 || m_tag == 1 || m_tag == 2 || m_tag == 5));
                chk("cyc_ring_on", int'(pic_ring_on), int'(m_tag == 3));
                chk("cyc_ball_on", int'(pic_ringball_on), int'(m_tag == 4));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One pixel strobe; returns one clock later (T+1).
    task automatic tick(input int x, input int y, input bit vid);
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        video_on = vid;
        p_tick = 1'b1;
        step();
        p_tick = 1'b0;
        $display("pix (%0d,%0d) vid=%0d ring=%0d rom_en=%0d rom_addr=%0d",
                 x, y, vid, ring_active, rom_en, rom_addr);
    endtask

    // flag: 0 none, 1 pic_on, 2 ring, 3 ringball
    task automatic run_pix(input string name, input int x, input int y, input bit vid,
                           input bit e_en, input int e_addr, input int flag);
        tick(x, y, vid);
        chk({name, "_en"}, int'(rom_en), int'(e_en));
        if (e_en) chk({name, "_addr"}, int'(rom_addr), e_addr);
        step();
        step();
        chk({name, "_rgb"}, int'(pic_RGB), e_en ? int'(rom_val(e_addr)) : 0);
        chk({name, "_on"}, int'(pic_on), int'(flag == 1));
        chk({name, "_ring"}, int'(pic_ring_on), int'(flag == 2));
        chk({name, "_ball"}, int'(pic_ringball_on), int'(flag == 3));
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int pat [6] = '{1, 1, 0, 0, 1, 1};
        reset = 1'b1;
        step();
        step();
        step();
        reset = 1'b0;
        chk_en = 1'b1;
        chk("rst_rom_en", int'(rom_en), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_rgb", int'(pic_RGB), 0);
        chk("rst_flags", int'({pic_on, pic_ring_on, pic_ringball_on}), 0);

        // First pixel, pinned literally.
        tick(320, 10, 1'b1);
        chk("hora_en", int'(rom_en), 1);
        chk("hora_addr", int'(rom_addr), 1344);
        step();
        chk("hora_en_once", int'(rom_en), 0);
        step();
        chk("hora_rgb", int'(pic_RGB), 8'hA5);
        chk("hora_on", int'(pic_on), 1);
        step();

        run_pix("fecha_a", 130, 420, 1'b1, 1'b1, 8514, 1);
        run_pix("fecha_b", 207, 447, 1'b1, 1'b1, 10751, 1);
        run_pix("fecha_miss", 208, 447, 1'b1, 1'b0, 0, 0);
        run_pix("timer", 420, 417, 1'b1, 1'b1, 10752 + 80 + 4, 1);
        run_pix("ring_idle", 520, 130, 1'b1, 1'b0, 0, 0);

        ring_active = 1'b1;
        step();
        step();
        run_pix("ring_on", 520, 130, 1'b1, 1'b1, 13576, 2);
        run_pix("ball", 544, 64, 1'b1, 1'b1, 21504, 3);
        run_pix("logo", 5, 3, 1'b1, 1'b1, 24197, 1);
        run_pix("logo_novid", 5, 3, 1'b0, 1'b0, 0, 0);
        run_pix("hora_over_logo", 256, 0, 1'b1, 1'b1, 0, 1);

        // Blink sequencing over six sparse frames.
        ring_active = 1'b0;
        step();
        step();
        ring_active = 1'b1;
        step();
        step();
        for (int f = 0; f < 6; f++) begin
            run_pix($sformatf("blink_f%0d", f), 520, 130, 1'b1, pat[f] == 1,
                    pat[f] == 1 ? 13576 : 0, pat[f] == 1 ? 2 : 0);
            tick(HL, VL, 1'b0);
            step();
        end

        // Alarm drop mid-frame: RING gone from the next strobe.
        ring_active = 1'b0;
        step();
        ring_active = 1'b1;
        step();
        step();
        run_pix("drop_before", 520, 130, 1'b1, 1'b1, 13576, 2);
        ring_active = 1'b0;
        run_pix("drop_after", 520, 130, 1'b1, 1'b0, 0, 0);
        run_pix("ball_off", 550, 70, 1'b1, 1'b0, 0, 0);

        // Back-to-back strobes.
        video_on = 1'b1;
        pixel_y = 10'd0;
        for (int i = 0; i < 4; i++) begin
            pixel_x = 10'(256 + i);
            p_tick = 1'b1;
            step();
            $display("pix (%0d,0) back-to-back rom_en=%0d rom_addr=%0d", 256 + i, rom_en, rom_addr);
            chk($sformatf("b2b_en%0d", i), int'(rom_en), 1);
            chk($sformatf("b2b_addr%0d", i), int'(rom_addr), i);
        end
        p_tick = 1'b0;
        chk("b2b_rgb1", int'(pic_RGB), int'(rom_val(1)));
        step();
        chk("b2b_rgb2", int'(pic_RGB), int'(rom_val(2)));
        step();
        chk("b2b_rgb3", int'(pic_RGB), int'(rom_val(3)));
        step();

        // Reset one clock after a strobe: nothing may emerge.
        tick(256, 0, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_mid_rgb%0d", k), int'(pic_RGB), 0);
            chk($sformatf("rst_mid_en%0d", k), int'(rom_en), 0);
            chk($sformatf("rst_mid_on%0d", k), int'(pic_on), 0);
            step();
        end
        run_pix("post_rst", 300, 20, 1'b1, 1'b1, 20 * 128 + 44, 1);

        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
